// File: rtl/spi_controller_if.sv
// Bundle of the SPI controller's request/response and serial-link signals.
interface spi_controller_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] din;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] dout;
    logic                  ss;
    logic                  sck;
    logic                  mosi;
    logic                  miso;

    // Controller view: drives the serial link and the status/result signals.
    modport master (
        input  start, din, miso,
        output ready, busy, done, dout, ss, sck, mosi
    );

    // Environment view: the requesting logic plus the attached peripheral.
    modport slave (
        output start, din, miso,
        input  ready, busy, done, dout, ss, sck, mosi
    );
endinterface

// File: rtl/spi_controller.sv
// Mode-0, MSB-first SPI master: one word per start, sck derived from clk by CLK_DIV.
module spi_controller #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_controller_if.master bus
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_HOLD
    } state_t;

    state_t                r_state;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_tx_sh;
    logic [DATA_WIDTH-1:0] r_rx_sh;
    logic                  r_ss;
    logic                  r_sck;
    logic                  r_mosi;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_dout;

    state_t                w_state_nxt;
    logic [DIV_W-1:0]      w_div_nxt;
    logic [CNT_W-1:0]      w_bit_nxt;
    logic [DATA_WIDTH-1:0] w_tx_nxt;
    logic [DATA_WIDTH-1:0] w_rx_nxt;
    logic                  w_ss_nxt;
    logic                  w_sck_nxt;
    logic                  w_mosi_nxt;
    logic                  w_ready_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [DATA_WIDTH-1:0] w_dout_nxt;
    logic                  w_phase_end;

    assign w_phase_end = (r_div_cnt == DIV_LAST);

    assign bus.ss    = r_ss;
    assign bus.sck   = r_sck;
    assign bus.mosi  = r_mosi;
    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.dout  = r_dout;

    // State and all registered outputs; synchronous reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_ss      <= 1'b1;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_tx_sh   <= w_tx_nxt;
            r_rx_sh   <= w_rx_nxt;
            r_ss      <= w_ss_nxt;
            r_sck     <= w_sck_nxt;
            r_mosi    <= w_mosi_nxt;
            r_ready   <= w_ready_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_dout    <= w_dout_nxt;
        end
    end

    // Next state and next register values; sck/mosi only move at phase ends.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = w_phase_end ? '0 : r_div_cnt + DIV_W'(1);
        w_bit_nxt   = r_bit_cnt;
        w_tx_nxt    = r_tx_sh;
        w_rx_nxt    = r_rx_sh;
        w_ss_nxt    = r_ss;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_ready_nxt = r_ready;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_dout_nxt  = r_dout;

        case (r_state)
            S_IDLE: begin
                w_div_nxt = '0;
                if (bus.start) begin
                    w_tx_nxt    = bus.din;
                    w_mosi_nxt  = bus.din[DATA_WIDTH-1];
                    w_ss_nxt    = 1'b0;
                    w_bit_nxt   = '0;
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (w_phase_end) begin
                    w_sck_nxt   = 1'b1;
                    w_rx_nxt    = {r_rx_sh[DATA_WIDTH-2:0], bus.miso};
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_phase_end) begin
                    w_sck_nxt = 1'b0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_bit_nxt   = r_bit_cnt + CNT_W'(1);
                        w_tx_nxt    = r_tx_sh << 1;
                        w_mosi_nxt  = r_tx_sh[DATA_WIDTH-2];
                        w_state_nxt = S_LOW;
                    end
                end
            end
            S_HOLD: begin
                if (w_phase_end) begin
                    w_ss_nxt    = 1'b1;
                    w_mosi_nxt  = 1'b0;
                    w_dout_nxt  = r_rx_sh;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_spi_controller.sv
// Directed bench: three controllers (CLK_DIV 2, 4, 1) with loopback or a mode-0 peripheral model.
module tb_spi_controller;
    localparam int unsigned DW = 8;
    localparam logic [DW-1:0] PER_WORD = 8'h3C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_controller_if #(.DATA_WIDTH(DW)) if_a ();
    spi_controller_if #(.DATA_WIDTH(DW)) if_b ();
    spi_controller_if #(.DATA_WIDTH(DW)) if_c ();

    spi_controller #(.CLK_DIV(2), .DATA_WIDTH(DW)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    spi_controller #(.CLK_DIV(4), .DATA_WIDTH(DW)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
    spi_controller #(.CLK_DIV(1), .DATA_WIDTH(DW)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

    logic          start_v [3];
    logic [DW-1:0] din_v   [3];
    logic [5:0]    st_w    [3];  // {ss, sck, mosi, ready, busy, done}
    logic [DW-1:0] dout_w  [3];
    logic [DW-1:0] m_tx = '0;
    logic [DW-1:0] m_rx = '0;

    assign if_a.start = start_v[0];
    assign if_b.start = start_v[1];
    assign if_c.start = start_v[2];
    assign if_a.din   = din_v[0];
    assign if_b.din   = din_v[1];
    assign if_c.din   = din_v[2];
    assign if_a.miso  = if_a.mosi;
    assign if_c.miso  = if_c.mosi;
    assign if_b.miso  = m_tx[DW-1];

    assign st_w[0] = {if_a.ss, if_a.sck, if_a.mosi, if_a.ready, if_a.busy, if_a.done};
    assign st_w[1] = {if_b.ss, if_b.sck, if_b.mosi, if_b.ready, if_b.busy, if_b.done};
    assign st_w[2] = {if_c.ss, if_c.sck, if_c.mosi, if_c.ready, if_c.busy, if_c.done};
    assign dout_w[0] = if_a.dout;
    assign dout_w[1] = if_b.dout;
    assign dout_w[2] = if_c.dout;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rise_cnt [3] = '{0, 0, 0};
    logic prev_sck [3] = '{1'b0, 1'b0, 1'b0};
    logic prev_ss_b   = 1'b1;
    logic prev_mosi_b = 1'b0;
    int   half_cnt = 0;
    int   half_bad = 0;
    int   mosi_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle observers: sck edge counts, mode-0 peripheral, timing rules on instance b.
    always @(negedge clk) begin
        if (prev_ss_b && !if_b.ss) m_tx = PER_WORD;
        else if (!if_b.ss && prev_sck[1] && !if_b.sck) m_tx = m_tx << 1;
        if (!if_b.ss && !prev_sck[1] && if_b.sck) m_rx = {m_rx[DW-2:0], if_b.mosi};

        if ((if_b.sck != prev_sck[1]) || (prev_ss_b && !if_b.ss)) begin
            if ((if_b.sck != prev_sck[1]) && (half_cnt != 4)) half_bad++;
            half_cnt = 1;
        end else begin
            half_cnt++;
        end
        if ((if_b.mosi != prev_mosi_b) && !(prev_sck[1] && !if_b.sck) && (if_b.ss == prev_ss_b))
            mosi_bad++;
        prev_ss_b   = if_b.ss;
        prev_mosi_b = if_b.mosi;

        for (int k = 0; k < 3; k++) begin
            if (!prev_sck[k] && st_w[k][4]) rise_cnt[k]++;
            prev_sck[k] = st_w[k][4];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer: latency from the start edge to done (0 = timed out) and ss-low cycle count.
    task automatic xfer(input int k, input logic [DW-1:0] d, output int lat, output int sslow);
        @(negedge clk);
        din_v[k]   = d;
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        lat   = 0;
        sslow = (st_w[k][5] == 1'b0) ? 1 : 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (st_w[k][0]) begin
                lat = n;
                break;
            end
            if (!st_w[k][5]) sslow++;
        end
    endtask

    int lat, sslow, base, hb0, mb0, ndone, gap, e0, t_done;
    logic [DW-1:0] got_d [2];

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            din_v[k]   = '0;
        end
        got_d[0] = '0;
        got_d[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_pins_%0d", k), 32'(st_w[k]), 32'(6'b100100));
            chk($sformatf("reset_dout_%0d", k), 32'(dout_w[k]), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Loopback, CLK_DIV=2.
        base = rise_cnt[0];
        xfer(0, 8'hA5, lat, sslow);
        chk("lb2_latency", lat, 34);
        chk("lb2_ss_low", sslow, 34);
        chk("lb2_dout", 32'(dout_w[0]), 32'hA5);
        @(posedge clk);
        #1;
        chk("lb2_rises", rise_cnt[0] - base, 8);
        chk("lb2_done_one_cycle", 32'(st_w[0][0]), 0);

        // Back-to-back with start held high.
        @(negedge clk);
        din_v[0]   = 8'h01;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        din_v[0] = 8'h80;
        ndone = 0;
        gap   = 0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            if (st_w[0][0]) begin
                if (ndone < 2) got_d[ndone] = dout_w[0];
                ndone++;
            end else if (ndone == 1) begin
                start_v[0] = 1'b0;
            end
            if (ndone == 1 && st_w[0][5]) gap++;
        end
        start_v[0] = 1'b0;
        chk("b2b_done_count", ndone, 2);
        chk("b2b_ss_gap", gap, 1);
        chk("b2b_dout0", 32'(got_d[0]), 32'h01);
        chk("b2b_dout1", 32'(got_d[1]), 32'h80);

        // CLK_DIV=1 corner.
        base = rise_cnt[2];
        xfer(2, 8'h69, lat, sslow);
        chk("div1_latency", lat, 17);
        chk("div1_dout", 32'(dout_w[2]), 32'h69);
        chk("div1_rises", rise_cnt[2] - base, 8);

        // Peripheral model, CLK_DIV=4.
        base = rise_cnt[1];
        hb0  = half_bad;
        mb0  = mosi_bad;
        xfer(1, 8'hC3, lat, sslow);
        @(negedge clk);
        chk("per_latency", lat, 68);
        chk("per_model_rx", 32'(m_rx), 32'hC3);
        chk("per_dout", 32'(dout_w[1]), 32'h3C);
        chk("per_rises", rise_cnt[1] - base, 8);
        chk("per_half_period", half_bad - hb0, 0);
        chk("per_mosi_timing", mosi_bad - mb0, 0);

        // Start pulsed mid-transfer is ignored.
        hb0 = half_bad;
        @(negedge clk);
        din_v[1]   = 8'h5A;
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        e0     = cyc;
        ndone  = 0;
        t_done = 0;
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk);
            #1;
            if (n == 20) begin
                chk("busy_mid_ready_busy", 32'({st_w[1][2], st_w[1][1]}), 32'(2'b01));
                din_v[1]   = 8'hFF;
                start_v[1] = 1'b1;
            end
            if (n == 21) start_v[1] = 1'b0;
            if (st_w[1][0]) begin
                ndone++;
                if (t_done == 0) t_done = cyc - e0;
            end
        end
        chk("busy_done_count", ndone, 1);
        chk("busy_latency", t_done, 68);
        chk("busy_model_rx", 32'(m_rx), 32'h5A);
        chk("busy_half_period", half_bad - hb0, 0);

        // Reset during the 4th sck high phase.
        base = rise_cnt[1];
        @(negedge clk);
        din_v[1]   = 8'hA5;
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        for (int n = 0; n < 300 && (rise_cnt[1] - base) < 4; n++) @(negedge clk);
        chk("rst_reached_4th_high", 32'({st_w[1][4], 4'(rise_cnt[1] - base)}), 32'h14);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_abort_pins", 32'(st_w[1]), 32'(6'b100100));
        chk("rst_abort_dout", 32'(dout_w[1]), 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (st_w[1][0]) ndone++;
        end
        chk("rst_no_done", ndone, 0);
        xfer(1, 8'h96, lat, sslow);
        @(negedge clk);
        chk("post_rst_latency", lat, 68);
        chk("post_rst_model_rx", 32'(m_rx), 32'h96);
        chk("post_rst_dout", 32'(dout_w[1]), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
